// File: rtl/brush_motor_pkg.sv
// Shared types, register map and helpers for the brushed-motor PWM driver.
package brush_motor_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_FWD,
      ST_REV,
      ST_BRAKE,
      ST_DEAD
   } motor_state_e;

   localparam logic [31:0] BRUSH_MOTOR_ID = 32'hEA680003;

   localparam logic [4:0] ADDR_ID      = 5'd0;
   localparam logic [4:0] ADDR_PERIOD  = 5'd1;
   localparam logic [4:0] ADDR_STATUS  = 5'd2;
   localparam logic [4:0] ADDR_PARAM   = 5'd3;
   localparam logic [4:0] ADDR_CH_BASE = 5'd8;

   localparam int unsigned CTRL_ON    = 0;
   localparam int unsigned CTRL_DIR   = 1;
   localparam int unsigned CTRL_BRAKE = 2;

   function automatic motor_state_e ctrl_target(input logic [2:0] ctrl);
      motor_state_e t;
      if (!ctrl[CTRL_ON])
         t = ST_OFF;
      else if (ctrl[CTRL_BRAKE])
         t = ST_BRAKE;
      else if (ctrl[CTRL_DIR])
         t = ST_FWD;
      else
         t = ST_REV;
      return t;
   endfunction

   function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                            input logic [31:0] wd,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = cur;
      for (int unsigned b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/brush_motor_channel.sv
// One H-bridge channel: mode FSM with dead-time insertion, duty shadow and
// registered bridge outputs.
module brush_motor_channel
   import brush_motor_pkg::*;
#(
   parameter int PWM_WIDTH = 8,
   parameter int DEADTIME  = 4
) (
   input  logic                 csi_MCLK_clk,
   input  logic                 rsi_MRST_reset,
   input  logic [2:0]           ctrl,
   input  logic [PWM_WIDTH-1:0] duty,
   input  logic [PWM_WIDTH-1:0] cnt,
   input  logic                 shadow_load,
   input  logic                 pwm_gate,
   output logic                 hx,
   output logic                 hy,
   output logic                 dead
);

   localparam logic [7:0] DEAD_INIT = 8'(DEADTIME - 1);

   motor_state_e         state_q, state_d;
   motor_state_e         dead_tgt_q, dead_tgt_d;
   motor_state_e         tgt;
   logic [7:0]           dead_cnt_q, dead_cnt_d;
   logic [PWM_WIDTH-1:0] shadow_q;
   logic                 pwm;
   logic                 hx_d, hy_d;

   assign tgt  = ctrl_target(ctrl);
   assign pwm  = pwm_gate && (cnt < shadow_q);
   assign dead = (state_q == ST_DEAD);

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         state_q    <= ST_OFF;
         dead_tgt_q <= ST_OFF;
         dead_cnt_q <= '0;
         shadow_q   <= '0;
         hx         <= 1'b0;
         hy         <= 1'b0;
      end else begin
         state_q    <= state_d;
         dead_tgt_q <= dead_tgt_d;
         dead_cnt_q <= dead_cnt_d;
         hx         <= hx_d;
         hy         <= hy_d;
         if (shadow_load) shadow_q <= duty;
      end
   end

   // A target change while DEAD re-arms the full dead time toward the new target.
   always_comb begin
      state_d    = state_q;
      dead_tgt_d = dead_tgt_q;
      dead_cnt_d = dead_cnt_q;
      hx_d       = 1'b0;
      hy_d       = 1'b0;

      if (tgt == ST_OFF) begin
         state_d    = ST_OFF;
         dead_cnt_d = '0;
      end else if (state_q == ST_DEAD) begin
         if (tgt != dead_tgt_q) begin
            dead_tgt_d = tgt;
            dead_cnt_d = DEAD_INIT;
         end else if (dead_cnt_q == '0) begin
            state_d = dead_tgt_q;
         end else begin
            dead_cnt_d = dead_cnt_q - 8'd1;
         end
      end else if (tgt != state_q) begin
         state_d    = ST_DEAD;
         dead_tgt_d = tgt;
         dead_cnt_d = DEAD_INIT;
      end

      case (state_q)
         ST_FWD:   hx_d = pwm;
         ST_REV:   hy_d = pwm;
         ST_BRAKE: begin
            hx_d = 1'b1;
            hy_d = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/brush_motor_pwm_driver.sv
// Multi-channel brushed-motor PWM driver: Avalon-MM register file, shared
// period counter and one brush_motor_channel per H-bridge.
module brush_motor_pwm_driver
   import brush_motor_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int PWM_WIDTH = 8,
   parameter int DEADTIME  = 4
) (
   input  logic                csi_MCLK_clk,
   input  logic                rsi_MRST_reset,
   input  logic [4:0]          avs_ctrl_address,
   input  logic [31:0]         avs_ctrl_writedata,
   input  logic [3:0]          avs_ctrl_byteenable,
   input  logic                avs_ctrl_write,
   input  logic                avs_ctrl_read,
   output logic [31:0]         avs_ctrl_readdata,
   output logic                avs_ctrl_waitrequest,
   output logic [CHANNELS-1:0] HX,
   output logic [CHANNELS-1:0] HY
);

   logic [PWM_WIDTH-1:0] period_q;
   logic [PWM_WIDTH-1:0] cnt_q;
   logic [2:0]           ctrl_q [CHANNELS];
   logic [PWM_WIDTH-1:0] duty_q [CHANNELS];
   logic [CHANNELS-1:0]  dead;
   logic                 period_zero, wrap, shadow_load;
   logic [3:0]           ch_idx;
   logic                 ch_hit;
   logic [31:0]          rd_data, wr_merged;
   logic                 unused_wr_hi;

   assign avs_ctrl_waitrequest = 1'b0;

   assign period_zero = (period_q == '0);
   assign wrap        = !period_zero && (cnt_q >= period_q - PWM_WIDTH'(1));
   assign shadow_load = period_zero || wrap;

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset)
         cnt_q <= '0;
      else if (shadow_load)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + PWM_WIDTH'(1);
   end

   // Channel c owns addresses 8+2c (CTRL) and 9+2c (DUTY).
   assign ch_idx = avs_ctrl_address[4:1] - 4'd4;
   assign ch_hit = (avs_ctrl_address >= ADDR_CH_BASE) && (int'(ch_idx) < CHANNELS);

   always_comb begin
      rd_data = '0;
      case (avs_ctrl_address)
         ADDR_ID:     rd_data = BRUSH_MOTOR_ID;
         ADDR_PERIOD: rd_data = 32'(period_q);
         ADDR_STATUS: rd_data = 32'(dead);
         ADDR_PARAM:  rd_data = {8'h00, 8'(DEADTIME), 8'(PWM_WIDTH), 8'(CHANNELS)};
         default: begin
            for (int unsigned c = 0; c < CHANNELS; c++)
               if (ch_hit && ch_idx == 4'(c))
                  rd_data = avs_ctrl_address[0] ? 32'(duty_q[c]) : 32'(ctrl_q[c]);
         end
      endcase
   end

   assign wr_merged    = be_merge(rd_data, avs_ctrl_writedata, avs_ctrl_byteenable);
   assign unused_wr_hi = ^wr_merged[31:PWM_WIDTH];

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         period_q          <= '0;
         avs_ctrl_readdata <= '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            ctrl_q[c] <= '0;
            duty_q[c] <= '0;
         end
      end else if (avs_ctrl_write) begin
         if (avs_ctrl_address == ADDR_PERIOD)
            period_q <= wr_merged[PWM_WIDTH-1:0];
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_hit && ch_idx == 4'(c)) begin
               if (avs_ctrl_address[0])
                  duty_q[c] <= wr_merged[PWM_WIDTH-1:0];
               else
                  ctrl_q[c] <= wr_merged[2:0];
            end
         end
      end else if (avs_ctrl_read) begin
         avs_ctrl_readdata <= rd_data;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      brush_motor_channel #(
         .PWM_WIDTH (PWM_WIDTH),
         .DEADTIME  (DEADTIME)
      ) u_ch (
         .csi_MCLK_clk   (csi_MCLK_clk),
         .rsi_MRST_reset (rsi_MRST_reset),
         .ctrl           (ctrl_q[g]),
         .duty           (duty_q[g]),
         .cnt            (cnt_q),
         .shadow_load    (shadow_load),
         .pwm_gate       (!period_zero),
         .hx             (HX[g]),
         .hy             (HY[g]),
         .dead           (dead[g])
      );
   end

endmodule

// File: tb/tb_brush_motor_pwm_driver.sv
// Bench for brush_motor_pwm_driver: directed scenarios plus random bus traffic,
// all checked every cycle against a behavioural model of the register map and bridges.
module tb_brush_motor_pwm_driver;

   localparam int CH = 2;
   localparam int PW = 8;
   localparam int DT = 4;

   localparam int M_OFF   = 0;
   localparam int M_FWD   = 1;
   localparam int M_REV   = 2;
   localparam int M_BRAKE = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    addr;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic          wr, rd;
   logic [31:0]   rdata;
   logic          waitreq;
   logic [CH-1:0] hx, hy;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // behavioural model state
   int            m_period, m_cnt;
   int            m_ctrl [CH];
   int            m_duty [CH];
   int            m_shadow [CH];
   int            m_mode [CH];
   int            m_goal [CH];
   int            m_dead_left [CH];
   logic [CH-1:0] m_hx, m_hy;
   logic [31:0]   m_rd;

   brush_motor_pwm_driver #(
      .CHANNELS  (CH),
      .PWM_WIDTH (PW),
      .DEADTIME  (DT)
   ) dut (
      .csi_MCLK_clk         (clk),
      .rsi_MRST_reset       (rst),
      .avs_ctrl_address     (addr),
      .avs_ctrl_writedata   (wdata),
      .avs_ctrl_byteenable  (be),
      .avs_ctrl_write       (wr),
      .avs_ctrl_read        (rd),
      .avs_ctrl_readdata    (rdata),
      .avs_ctrl_waitrequest (waitreq),
      .HX                   (hx),
      .HY                   (hy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int target_of(input int ctrl);
      if ((ctrl & 1) == 0) return M_OFF;
      if ((ctrl & 4) != 0) return M_BRAKE;
      if ((ctrl & 2) != 0) return M_FWD;
      return M_REV;
   endfunction

   function automatic logic [31:0] be_apply(input logic [31:0] cur, input logic [31:0] wd,
                                            input logic [3:0] b);
      logic [31:0] r;
      logic [31:0] lane;
      r = cur;
      for (int i = 0; i < 4; i++) begin
         lane = 32'hFF << (8 * i);
         if (b[i]) r = (r & ~lane) | (wd & lane);
      end
      return r;
   endfunction

   function automatic logic [31:0] reg_value(input int a);
      logic [31:0] v;
      int c;
      v = '0;
      if (a == 0) v = 32'hEA680003;
      else if (a == 1) v = 32'(m_period);
      else if (a == 2) begin
         for (int i = 0; i < CH; i++)
            if (m_dead_left[i] > 0) v = v | (32'd1 << i);
      end else if (a == 3) v = 32'(DT * 65536 + PW * 256 + CH);
      else if (a >= 8) begin
         c = (a - 8) / 2;
         if (c < CH) v = (a % 2 == 0) ? 32'(m_ctrl[c]) : 32'(m_duty[c]);
      end
      return v;
   endfunction

   task automatic model_step();
      bit pwm, wrap_now;
      int tgt, a, c;
      if (rst) begin
         m_period = 0;
         m_cnt    = 0;
         m_rd     = '0;
         m_hx     = '0;
         m_hy     = '0;
         for (int i = 0; i < CH; i++) begin
            m_ctrl[i] = 0; m_duty[i] = 0; m_shadow[i] = 0;
            m_mode[i] = M_OFF; m_goal[i] = M_OFF; m_dead_left[i] = 0;
         end
         return;
      end
      for (int i = 0; i < CH; i++) begin
         pwm     = (m_period > 0) && (m_cnt < m_shadow[i]);
         m_hx[i] = (m_dead_left[i] == 0) && (m_mode[i] == M_BRAKE || (m_mode[i] == M_FWD && pwm));
         m_hy[i] = (m_dead_left[i] == 0) && (m_mode[i] == M_BRAKE || (m_mode[i] == M_REV && pwm));
      end
      a = int'(addr);
      if (rd && !wr) m_rd = reg_value(a);
      for (int i = 0; i < CH; i++) begin
         tgt = target_of(m_ctrl[i]);
         if (tgt == M_OFF) begin
            m_mode[i] = M_OFF;
            m_dead_left[i] = 0;
         end else if (m_dead_left[i] > 0) begin
            if (tgt != m_goal[i]) begin
               m_goal[i] = tgt;
               m_dead_left[i] = DT;
            end else begin
               m_dead_left[i]--;
               if (m_dead_left[i] == 0) m_mode[i] = m_goal[i];
            end
         end else if (tgt != m_mode[i]) begin
            m_goal[i] = tgt;
            m_dead_left[i] = DT;
         end
      end
      wrap_now = (m_period == 0) || (m_cnt + 1 >= m_period);
      if (wrap_now)
         for (int i = 0; i < CH; i++) m_shadow[i] = m_duty[i];
      m_cnt = wrap_now ? 0 : m_cnt + 1;
      if (wr) begin
         if (a == 1) m_period = int'(be_apply(32'(m_period), wdata, be) & 32'hFF);
         else if (a >= 8) begin
            c = (a - 8) / 2;
            if (c < CH) begin
               if (a % 2 == 0) m_ctrl[c] = int'(be_apply(32'(m_ctrl[c]), wdata, be) & 32'h7);
               else            m_duty[c] = int'(be_apply(32'(m_duty[c]), wdata, be) & 32'hFF);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_val("hx", 32'(hx), 32'(m_hx));
         check_val("hy", 32'(hy), 32'(m_hy));
         check_val("readdata", rdata, m_rd);
         check_val("waitrequest", 32'(waitreq), 32'h0);
      end
   end

   task automatic bus_cycle(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b,
                            input logic w, input logic r);
      addr = a; wdata = d; be = b; wr = w; rd = r;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      bus_cycle(a, d, 4'hF, 1'b1, 1'b0);
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      bus_cycle(a, 32'h0, 4'h0, 1'b0, 1'b1);
      d = rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_high(input int n, input int ch, output int nx, output int ny);
      nx = 0; ny = 0;
      repeat (n) begin
         @(negedge clk);
         nx += int'(hx[ch]);
         ny += int'(hy[ch]);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      logic [4:0]  ra;
      logic [31:0] rdat;
      logic [3:0]  rbe;
      int nx, ny, sel, ch;

      rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check_val("rst_hx", 32'(hx), 32'h0);
      check_val("rst_hy", 32'(hy), 32'h0);
      check_val("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      idle(2);

      // identification and parameter readback
      bus_read(5'd0, d);  check_val("id", d, 32'hEA680003);
      bus_read(5'd3, d);  check_val("param", d, 32'h00040802);
      bus_read(5'd12, d); check_val("ch2_ctrl", d, 32'h0);
      bus_read(5'd5, d);  check_val("unmapped", d, 32'h0);
      bus_cycle(5'd1, 32'h0000FFFF, 4'b0001, 1'b1, 1'b0);
      bus_read(5'd1, d);  check_val("period_be", d, 32'h000000FF);

      // channel 0 forward, 3/10
      bus_write(5'd1, 32'd10);
      bus_write(5'd9, 32'd3);
      bus_write(5'd8, 32'd3);
      idle(30);
      count_high(20, 0, nx, ny);
      check_val("fwd_hx_cnt", 32'(nx), 32'd6);
      check_val("fwd_hy_cnt", 32'(ny), 32'd0);

      // reverse through dead time
      bus_write(5'd8, 32'd1);
      idle(1);
      bus_read(5'd2, d);  check_val("status_dead", d, 32'h1);
      idle(20);
      count_high(20, 0, nx, ny);
      check_val("rev_hx_cnt", 32'(nx), 32'd0);
      check_val("rev_hy_cnt", 32'(ny), 32'd6);
      bus_read(5'd2, d);  check_val("status_idle", d, 32'h0);

      // duty change mid-period takes effect next period
      for (int i = 0; i < 40 && m_cnt != 5; i++) @(negedge clk);
      check_val("cnt_sync", 32'(m_cnt), 32'd5);
      bus_write(5'd9, 32'd7);
      count_high(14, 0, nx, ny);
      check_val("duty7_tail", 32'(ny), 32'd7);
      bus_write(5'd9, 32'd20);
      idle(25);
      count_high(20, 0, nx, ny);
      check_val("duty_full", 32'(ny), 32'd20);

      // channel 1 brake, then off
      bus_write(5'd10, 32'd5);
      idle(10);
      check_val("brake_hx1", 32'(hx[1]), 32'h1);
      check_val("brake_hy1", 32'(hy[1]), 32'h1);
      bus_write(5'd10, 32'd0);
      idle(1);
      check_val("off_lag_hx1", 32'(hx[1]), 32'h1);
      idle(1);
      check_val("off_hx1", 32'(hx[1]), 32'h0);
      check_val("off_hy1", 32'(hy[1]), 32'h0);

      // reset in the middle of dead time
      bus_write(5'd8, 32'd3);
      idle(1);
      rst = 1'b1;
      @(negedge clk);
      check_val("rstdead_hx", 32'(hx), 32'h0);
      check_val("rstdead_hy", 32'(hy), 32'h0);
      rst = 1'b0;
      bus_read(5'd1, d); check_val("rst_period", d, 32'h0);
      bus_read(5'd8, d); check_val("rst_ctrl0", d, 32'h0);
      bus_read(5'd9, d); check_val("rst_duty0", d, 32'h0);
      idle(6);
      bus_read(5'd2, d); check_val("rst_status", d, 32'h0);

      // random traffic against the model
      for (int it = 0; it < 1500; it++) begin
         sel = $urandom_range(0, 99);
         ch  = $urandom_range(0, 2);
         case ($urandom_range(0, 5))
            0:       begin ra = 5'd1;             rdat = 32'($urandom_range(0, 20)); end
            1, 2:    begin ra = 5'(8 + 2 * ch);   rdat = 32'($urandom_range(0, 7));  end
            3, 4:    begin ra = 5'(9 + 2 * ch);   rdat = 32'($urandom_range(0, 24)); end
            default: begin ra = 5'($urandom_range(0, 31)); rdat = $urandom;    end
         endcase
         rbe = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         if (sel < 3) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (sel < 35) begin
            bus_cycle(ra, rdat, rbe, 1'b1, 1'b0);
         end else if (sel < 55) begin
            bus_cycle(ra, rdat, rbe, ($urandom_range(0, 4) == 0), 1'b1);
         end else begin
            idle(1 + $urandom_range(0, 6));
         end
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
